// File: rtl/i2c_passthru_pkg.sv
// Shared state encoding, default bit timing and helpers for the I2C pass-through bit transmitter.
package i2c_passthru_pkg;

  localparam int unsigned F_REF_T_R_DFLT            = 15;
  localparam int unsigned F_REF_T_SU_DAT_DFLT       = 2;
  localparam int unsigned F_REF_T_LOW_DFLT          = 38;
  localparam int unsigned WIDTH_F_REF_T_R_DFLT      = 4;
  localparam int unsigned WIDTH_F_REF_T_SU_DAT_DFLT = 2;
  localparam int unsigned WIDTH_F_REF_T_LOW_DFLT    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_SETUP,
    ST_RISE,
    ST_HIGH,
    ST_DONE
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_passthru_tick_cnt.sv
// f_ref rising-edge detector and saturating per-phase tick counter.
// A clear in the same cycle as a tick restarts the count at one.
module i2c_passthru_tick_cnt #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_f_ref,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  logic             r_f_ref_q;
  logic [WIDTH-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = i_f_ref & ~r_f_ref_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_f_ref_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_f_ref_q <= i_f_ref;
      if (i_clr) begin
        r_cnt <= w_tick ? WIDTH'(1) : '0;
      end else if (w_tick && (r_cnt != '1)) begin
        r_cnt <= r_cnt + WIDTH'(1);
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/i2c_passthru_bittx.sv
// Relays one received I2C bit onto the other bus segment with open-drain SCL/SDA drive.
// Define I2C_PASSTHRU_BITTX_VIOLATION_EN to build in the sticky SDA mismatch detector.
module i2c_passthru_bittx
  import i2c_passthru_pkg::*;
#(
  parameter int unsigned F_REF_T_R            = F_REF_T_R_DFLT,
  parameter int unsigned F_REF_T_SU_DAT       = F_REF_T_SU_DAT_DFLT,
  parameter int unsigned F_REF_T_LOW          = F_REF_T_LOW_DFLT,
  parameter int unsigned WIDTH_F_REF_T_R      = WIDTH_F_REF_T_R_DFLT,
  parameter int unsigned WIDTH_F_REF_T_SU_DAT = WIDTH_F_REF_T_SU_DAT_DFLT,
  parameter int unsigned WIDTH_F_REF_T_LOW    = WIDTH_F_REF_T_LOW_DFLT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_f_ref,
  input  logic i_start_tx,
  input  logic i_tx_is_to_mst,
  input  logic i_rx_sda_init_valid,
  input  logic i_rx_sda_init,
  input  logic i_rx_sda_mid_change,
  input  logic i_rx_sda_final,
  input  logic i_rx_done,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda,
  output logic o_tx_done,
  output logic o_violation
);

  localparam int unsigned WIDTH_CNT =
    max_u(max_u(WIDTH_F_REF_T_R, WIDTH_F_REF_T_SU_DAT), WIDTH_F_REF_T_LOW);

  state_t               r_state;
  logic                 r_scl;
  logic                 r_sda;
  logic                 r_tx_done;
  logic                 r_to_mst;
  logic                 r_seen_done;
  logic                 r_seen_low;
  logic                 r_final;
  logic                 w_exit;
  logic [WIDTH_CNT-1:0] w_cnt;

  // Phase counter restarts whenever the state machine leaves its current state.
  i2c_passthru_tick_cnt #(
    .WIDTH (WIDTH_CNT)
  ) u_tick_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_f_ref (i_f_ref),
    .i_clr   (w_exit),
    .o_cnt   (w_cnt)
  );

  // Leave-current-state condition, shared by the FSM and the counter clear.
  always_comb begin
    w_exit = 1'b0;
    case (r_state)
      ST_IDLE:  w_exit = i_start_tx;
      ST_LOW:   w_exit = i_rx_sda_init_valid &
                         (r_to_mst | (w_cnt >= WIDTH_CNT'(F_REF_T_LOW)));
      ST_SETUP: w_exit = (w_cnt >= WIDTH_CNT'(F_REF_T_SU_DAT));
      ST_RISE:  w_exit = i_scl;
      ST_HIGH:  w_exit = r_to_mst ? ((i_rx_done | r_seen_done) & (~i_scl | r_seen_low))
                                  : i_rx_done;
      default:  w_exit = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_scl       <= 1'b1;
      r_sda       <= 1'b1;
      r_tx_done   <= 1'b0;
      r_to_mst    <= 1'b0;
      r_seen_done <= 1'b0;
      r_seen_low  <= 1'b0;
      r_final     <= 1'b1;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_exit) begin
          r_to_mst <= i_tx_is_to_mst;
          r_scl    <= 1'b0;
          r_state  <= ST_LOW;
        end
        ST_LOW: if (w_exit) begin
          r_sda   <= i_rx_sda_init;
          r_state <= ST_SETUP;
        end
        ST_SETUP: if (w_exit) begin
          r_scl   <= 1'b1;
          r_state <= ST_RISE;
        end
        ST_RISE: if (w_exit) begin
          r_seen_done <= 1'b0;
          r_seen_low  <= 1'b0;
          r_state     <= ST_HIGH;
        end
        ST_HIGH: begin
          if (w_exit) begin
            // A completion seen earlier supplies the final level captured with it.
            r_sda     <= i_rx_done ? i_rx_sda_final : r_final;
            r_scl     <= 1'b0;
            r_tx_done <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            if (i_rx_sda_mid_change) r_sda <= ~r_sda;
            if (i_rx_done) begin
              r_seen_done <= 1'b1;
              r_final     <= i_rx_sda_final;
            end
            if (r_to_mst && !i_scl) begin
              r_scl      <= 1'b0;
              r_seen_low <= 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_scl     = r_scl;
  assign o_sda     = r_sda;
  assign o_tx_done = r_tx_done;

`ifdef I2C_PASSTHRU_BITTX_VIOLATION_EN
  logic r_violation;

  // Sticky once the sensed SDA disagrees with our drive after the rise allowance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_violation <= 1'b0;
    end else if ((r_state == ST_IDLE) && i_start_tx) begin
      r_violation <= 1'b0;
    end else if ((r_state == ST_HIGH) && (w_cnt >= WIDTH_CNT'(F_REF_T_R)) &&
                 (i_sda != r_sda)) begin
      r_violation <= 1'b1;
    end
  end

  assign o_violation = r_violation;
`else
  logic w_unused_sda;
  assign w_unused_sda = i_sda;
  assign o_violation  = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_passthru_bittx.sv
// Randomized bench for i2c_passthru_bittx against a phase-level tick-counting model.
module tb_i2c_passthru_bittx;

  localparam int unsigned T_R   = 15;
  localparam int unsigned T_SU  = 2;
  localparam int unsigned T_LOW = 38;
`ifdef I2C_PASSTHRU_BITTX_VIOLATION_EN
  localparam bit VIOL_EN = 1'b1;
`else
  localparam bit VIOL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, f_ref, start, dir, init_valid, init, mid, fin, done;
  logic ext_scl, ext_sda;
  logic scl_in, sda_in;
  logic o_scl, o_sda, o_tx_done, o_violation;

  int          n_chk;
  int          n_bad;
  bit          f_prev;
  bit          tick_edge;
  int unsigned tk;
  bit          exp_sda;
  bit          exp_viol;

  always #5 clk = ~clk;

  // Wired-AND bus: the far side can pull either line low.
  assign scl_in = o_scl & ext_scl;
  assign sda_in = o_sda & ext_sda;

  i2c_passthru_bittx dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_f_ref             (f_ref),
    .i_start_tx          (start),
    .i_tx_is_to_mst      (dir),
    .i_rx_sda_init_valid (init_valid),
    .i_rx_sda_init       (init),
    .i_rx_sda_mid_change (mid),
    .i_rx_sda_final      (fin),
    .i_rx_done           (done),
    .i_scl               (scl_in),
    .i_sda               (sda_in),
    .o_scl               (o_scl),
    .o_sda               (o_sda),
    .o_tx_done           (o_tx_done),
    .o_violation         (o_violation)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: random f_ref, edge, note whether that edge saw a tick, settle.
  task automatic step();
    if ($urandom_range(0, 3) == 0) f_ref = ~f_ref;
    @(posedge clk);
    tick_edge = f_ref & ~f_prev;
    f_prev    = rst ? 1'b0 : f_ref;
    #1;
  endtask

  // One cycle spent in the high phase: apply the mismatch rule, then advance.
  task automatic hstep();
    if (VIOL_EN && (tk >= T_R) && exp_sda && !ext_sda) exp_viol = 1'b1;
    step();
    tk = tk + (tick_edge ? 32'd1 : 32'd0);
  endtask

  task automatic do_start(input bit dir_i);
    start = 1'b1;
    dir   = dir_i;
    step();
    start    = 1'b0;
    exp_viol = 1'b0;
    tk       = tick_edge ? 32'd1 : 32'd0;
    check("start_scl", o_scl, 1'b0);
    check("start_sda_hold", o_sda, exp_sda);
    check("start_viol_clr", o_violation, 1'b0);
  endtask

  task automatic do_low(input bit dir_i, input bit init_i, input int delay, output bit ok);
    bit exit_now;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      init_valid = (c >= delay);
      init       = init_valid ? init_i : ~init_i;
      exit_now   = init_valid && (dir_i || (tk >= T_LOW));
      step();
      if (exit_now) begin
        exp_sda = init_i;
        check("low_exit_sda", o_sda, exp_sda);
        check("low_exit_scl", o_scl, 1'b0);
        tk = tick_edge ? 32'd1 : 32'd0;
        ok = 1'b1;
        break;
      end
      check("low_scl", o_scl, 1'b0);
      check("low_sda_hold", o_sda, exp_sda);
      tk = tk + (tick_edge ? 32'd1 : 32'd0);
    end
    init_valid = 1'b0;
    if (!ok) check("low_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_setup(output bit ok);
    bit exit_now;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      exit_now = (tk >= T_SU);
      step();
      if (exit_now) begin
        check("setup_exit_scl", o_scl, 1'b1);
        check("setup_exit_sda", o_sda, exp_sda);
        ok = 1'b1;
        break;
      end
      check("setup_scl", o_scl, 1'b0);
      tk = tk + (tick_edge ? 32'd1 : 32'd0);
    end
    if (!ok) check("setup_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_rise(input int stretch, output bit ok);
    bit exit_now;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      ext_scl  = (c >= stretch);
      exit_now = ext_scl;
      step();
      check("rise_scl", o_scl, 1'b1);
      check("rise_viol", o_violation, exp_viol);
      if (exit_now) begin
        tk = tick_edge ? 32'd1 : 32'd0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rise_timeout", 1'b0, 1'b1);
  endtask

  task automatic high_body(input int hold, input int n_mid, input bit fault);
    int left;
    bit pulsed;
    left = n_mid;
    for (int c = 0; c < 2000; c++) begin
      if (fault ? (tk >= T_R + 2) : (c >= hold)) break;
      ext_sda = ~fault;
      pulsed  = (left > 0) && (c % 3 == 1);
      mid     = pulsed;
      hstep();
      mid = 1'b0;
      if (pulsed) begin
        exp_sda = ~exp_sda;
        left--;
      end
      check("high_sda", o_sda, exp_sda);
      check("high_scl", o_scl, 1'b1);
      check("high_txd", o_tx_done, 1'b0);
      check("high_viol", o_violation, exp_viol);
    end
    ext_sda = 1'b1;
    if (fault) check("viol_set", o_violation, VIOL_EN);
  endtask

  task automatic check_exit(input bit fin_i);
    exp_sda = fin_i;
    check("exit_sda", o_sda, exp_sda);
    check("exit_scl", o_scl, 1'b0);
    check("exit_txd", o_tx_done, 1'b1);
    check("exit_viol", o_violation, exp_viol);
    step();
    check("txd_single", o_tx_done, 1'b0);
    check("idle_scl_hold", o_scl, 1'b0);
    check("idle_sda_hold", o_sda, exp_sda);
    step();
    check("idle_txd", o_tx_done, 1'b0);
  endtask

  task automatic run_bit(input bit dir_i, input bit init_i, input bit fin_i, input int delay,
                         input int stretch, input int hold, input int n_mid, input bit fault,
                         input int mode);
    bit ok;
    int k;
    do_start(dir_i);
    do_low(dir_i, init_i, delay, ok);
    if (!ok) return;
    do_setup(ok);
    if (!ok) return;
    do_rise(stretch, ok);
    if (!ok) return;
    high_body(hold, n_mid, fault);
    fin = fin_i;
    k   = int'($urandom_range(0, 3));
    if (!dir_i || (mode == 0)) begin
      done = 1'b1;
      if (dir_i) ext_scl = 1'b0;
      hstep();
      done = 1'b0;
    end else if (mode == 1) begin
      ext_scl = 1'b0;
      for (int c = 0; c <= k; c++) begin
        hstep();
        check("stretch_scl", o_scl, 1'b0);
        check("stretch_sda", o_sda, exp_sda);
        check("stretch_txd", o_tx_done, 1'b0);
      end
      done = 1'b1;
      hstep();
      done = 1'b0;
    end else begin
      done = 1'b1;
      hstep();
      done = 1'b0;
      check("wait_low_scl", o_scl, 1'b1);
      check("wait_low_txd", o_tx_done, 1'b0);
      for (int c = 0; c < k; c++) begin
        hstep();
        check("wait_low_scl", o_scl, 1'b1);
        check("wait_low_txd", o_tx_done, 1'b0);
      end
      ext_scl = 1'b0;
      hstep();
    end
    check_exit(fin_i);
  endtask

  initial begin
    bit ok;
    bit r_dir, r_init, r_fault;
    int r_mid;
    n_chk = 0;      n_bad = 0;
    rst = 1'b1;     f_ref = 1'b0;   f_prev = 1'b0;  start = 1'b1;  dir = 1'b0;
    init_valid = 1'b0; init = 1'b0; mid = 1'b0;     fin = 1'b0;    done = 1'b0;
    ext_scl = 1'b1; ext_sda = 1'b1; tk = 0;
    exp_sda = 1'b1; exp_viol = 1'b0;

    // Reset held together with start: start must not be taken.
    repeat (3) step();
    check("rst_scl", o_scl, 1'b1);
    check("rst_sda", o_sda, 1'b1);
    check("rst_txd", o_tx_done, 1'b0);
    check("rst_viol", o_violation, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    step();
    check("post_rst_idle_scl", o_scl, 1'b1);
    check("post_rst_idle_sda", o_sda, 1'b1);

    run_bit(1'b1, 1'b1, 1'b1, 1, 0, 4, 0, 1'b0, 0);
    run_bit(1'b0, 1'b0, 1'b1, 0, 0, 4, 0, 1'b0, 0);
    run_bit(1'b0, 1'b0, 1'b1, 0, 2, 6, 1, 1'b0, 0);
    run_bit(1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 1'b1, 0);
    run_bit(1'b1, 1'b0, 1'b0, 2, 1, 5, 2, 1'b0, 1);

    // Reset while in SETUP aborts the bit silently.
    do_start(1'b0);
    do_low(1'b0, 1'b0, 0, ok);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_sda  = 1'b1;
    exp_viol = 1'b0;
    check("abort_scl", o_scl, 1'b1);
    check("abort_sda", o_sda, 1'b1);
    check("abort_txd", o_tx_done, 1'b0);
    check("abort_viol", o_violation, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      check("abort_no_txd", o_tx_done, 1'b0);
      check("abort_scl_idle", o_scl, 1'b1);
    end

    for (int b = 0; b < 16; b++) begin
      r_dir   = 1'($urandom_range(0, 1));
      r_init  = 1'($urandom_range(0, 1));
      r_mid   = int'($urandom_range(0, 3));
      r_fault = !r_dir && r_init && (r_mid == 0) && ($urandom_range(0, 1) == 1);
      run_bit(r_dir, r_init, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 40)), r_mid, r_fault,
              int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
